paddle_oneshot: RTL and testbench

//  Converts an absolute 8-bit paddle position into the per-frame vertical paddle

---
 rtl/paddle_oneshot_if.sv | 20 ++
 rtl/paddle_oneshot.sv | 113 +++++++++++
 tb/tb_paddle_oneshot.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/paddle_oneshot_if.sv
// rtl/paddle_oneshot_if.sv - sync, position and paddle-window signals for one player
interface paddle_oneshot_if;
   logic       hsync;
   logic       vsync;
   logic [7:0] vpos_in;
   logic       vpos_valid;
   logic       pad_active;
   logic       pad_start;
   logic [7:0] frame_vpos;

   modport master (
      output hsync, vsync, vpos_in, vpos_valid,
      input  pad_active, pad_start, frame_vpos
   );

   modport slave (
      input  hsync, vsync, vpos_in, vpos_valid,
      output pad_active, pad_start, frame_vpos
   );
endinterface

// File: rtl/paddle_oneshot.sv
// rtl/paddle_oneshot.sv - per-frame paddle window generator emulating the pot + 555 one-shot
module paddle_oneshot #(
   parameter int V_OFFSET = 16,
   parameter int V_RANGE  = 200,
   parameter int PAD_H    = 16,
   parameter int LINE_W   = 9
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   paddle_oneshot_if.slave  pad
);

   typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, DONE} state_t;

   localparam logic [LINE_W-1:0] LINE_MAX = '1;
   localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
   localparam logic [LINE_W-1:0] PAD_H_L  = LINE_W'(PAD_H);
   localparam logic [LINE_W-1:0] V_OFF_L  = LINE_W'(V_OFFSET);

   state_t            state, state_nx;
   logic              hs_d, vs_d;
   logic              hs_rise, vs_rise;
   logic [7:0]        vpos_hold;
   logic [7:0]        frame_vpos_q, frame_vpos_nx;
   logic [LINE_W-1:0] line_cnt, line_cnt_nx;
   logic [LINE_W-1:0] act_cnt, act_cnt_nx;
   logic [LINE_W-1:0] start_line, start_line_nx;
   logic [LINE_W-1:0] start_calc;
   logic [7:0]        travel;
   logic              pad_active_q, pad_start_q;
   logic              pad_start_nx;

   assign hs_rise = pad.hsync & ~hs_d;
   assign vs_rise = pad.vsync & ~vs_d;

   // Product is kept to 16 bits before taking the integer part of the scaled travel
   assign travel     = 8'((16'(vpos_hold) * 16'(V_RANGE)) >> 8);
   assign start_calc = V_OFF_L + LINE_W'(travel);

   always_comb begin
      state_nx      = state;
      line_cnt_nx   = line_cnt;
      act_cnt_nx    = act_cnt;
      start_line_nx = start_line;
      frame_vpos_nx = frame_vpos_q;
      pad_start_nx  = 1'b0;

      if (vs_rise) begin
         frame_vpos_nx = vpos_hold;
         line_cnt_nx   = '0;
         act_cnt_nx    = '0;
         start_line_nx = start_calc;
         if (start_calc == '0) begin
            state_nx     = ACTIVE;
            pad_start_nx = 1'b1;
         end else begin
            state_nx = DELAY;
         end
      end else if (hs_rise) begin
         case (state)
            DELAY: begin
               if (line_cnt != LINE_MAX) begin
                  line_cnt_nx = line_cnt + LINE_ONE;
                  if (line_cnt + LINE_ONE == start_line) begin
                     state_nx     = ACTIVE;
                     pad_start_nx = 1'b1;
                  end
               end
            end
            ACTIVE: begin
               act_cnt_nx = act_cnt + LINE_ONE;
               if (act_cnt + LINE_ONE == PAD_H_L) begin
                  state_nx = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         hs_d         <= 1'b0;
         vs_d         <= 1'b0;
         vpos_hold    <= '0;
         frame_vpos_q <= '0;
         line_cnt     <= '0;
         act_cnt      <= '0;
         start_line   <= '0;
         pad_active_q <= 1'b0;
         pad_start_q  <= 1'b0;
      end else begin
         state        <= state_nx;
         hs_d         <= pad.hsync;
         vs_d         <= pad.vsync;
         if (pad.vpos_valid) begin
            vpos_hold <= pad.vpos_in;
         end
         frame_vpos_q <= frame_vpos_nx;
         line_cnt     <= line_cnt_nx;
         act_cnt      <= act_cnt_nx;
         start_line   <= start_line_nx;
         pad_active_q <= (state_nx == ACTIVE);
         pad_start_q  <= pad_start_nx;
      end
   end

   assign pad.pad_active = pad_active_q;
   assign pad.pad_start  = pad_start_q;
   assign pad.frame_vpos = frame_vpos_q;

endmodule

// File: tb/tb_paddle_oneshot.sv
// tb/tb_paddle_oneshot.sv - directed bench for paddle_oneshot (default and zero-offset instances)
module tb_paddle_oneshot;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       hsync = 1'b0;
   logic       vsync = 1'b0;
   logic [7:0] vpos_in = 8'd0;
   logic       vpos_valid = 1'b0;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   paddle_oneshot_if if0 ();
   paddle_oneshot_if if1 ();

   assign if0.hsync = hsync;
   assign if0.vsync = vsync;
   assign if0.vpos_in = vpos_in;
   assign if0.vpos_valid = vpos_valid;
   assign if1.hsync = hsync;
   assign if1.vsync = vsync;
   assign if1.vpos_in = vpos_in;
   assign if1.vpos_valid = vpos_valid;

   paddle_oneshot u0 (.clk_sys(clk), .reset_n(reset_n), .pad(if0));
   paddle_oneshot #(.V_OFFSET(0)) u1 (.clk_sys(clk), .reset_n(reset_n), .pad(if1));

   task automatic hs_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) hsync = 1'b1;
         @(negedge clk) hsync = 1'b0;
      end
   endtask

   task automatic vs_pulse();
      @(negedge clk) vsync = 1'b1;
      @(negedge clk) vsync = 1'b0;
   endtask

   task automatic set_vpos(input logic [7:0] v);
      @(negedge clk) begin vpos_in = v; vpos_valid = 1'b1; end
      @(negedge clk) vpos_valid = 1'b0;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check("reset pad_active", int'(if0.pad_active), 0);
      check("reset pad_start", int'(if0.pad_start), 0);
      check("reset frame_vpos", int'(if0.frame_vpos), 0);
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic test_vpos0();
      set_vpos(8'd0);
      vs_pulse();
      check("v0 after vs", int'(if0.pad_active), 0);
      hs_pulses(15);
      check("v0 hs15", int'(if0.pad_active), 0);
      @(negedge clk) hsync = 1'b1;
      @(negedge clk);
      check("v0 hs16 active", int'(if0.pad_active), 1);
      check("v0 hs16 start", int'(if0.pad_start), 1);
      hsync = 1'b0;
      @(negedge clk);
      check("v0 start 1 cycle", int'(if0.pad_start), 0);
      hs_pulses(15);
      check("v0 hs31", int'(if0.pad_active), 1);
      hs_pulses(1);
      check("v0 hs32", int'(if0.pad_active), 0);
      hs_pulses(20);
      check("v0 no 2nd window", int'(if0.pad_active), 0);
   endtask

   task automatic test_vpos_range();
      set_vpos(8'd255);
      vs_pulse();
      check("v255 frame_vpos", int'(if0.frame_vpos), 255);
      hs_pulses(214);
      check("v255 hs214", int'(if0.pad_active), 0);
      hs_pulses(1);
      check("v255 hs215", int'(if0.pad_active), 1);
      hs_pulses(15);
      check("v255 hs230", int'(if0.pad_active), 1);
      hs_pulses(1);
      check("v255 hs231", int'(if0.pad_active), 0);
      set_vpos(8'd128);
      vs_pulse();
      hs_pulses(115);
      check("v128 hs115", int'(if0.pad_active), 0);
      hs_pulses(1);
      check("v128 hs116", int'(if0.pad_active), 1);
   endtask

   task automatic test_midframe_load();
      set_vpos(8'd0);
      vs_pulse();
      hs_pulses(5);
      set_vpos(8'd200);
      check("mid frame_vpos old", int'(if0.frame_vpos), 0);
      hs_pulses(10);
      check("mid hs15", int'(if0.pad_active), 0);
      hs_pulses(1);
      check("mid hs16", int'(if0.pad_active), 1);
      hs_pulses(20);
      vs_pulse();
      check("mid frame_vpos new", int'(if0.frame_vpos), 200);
      hs_pulses(171);
      check("mid next hs171", int'(if0.pad_active), 0);
      hs_pulses(1);
      check("mid next hs172", int'(if0.pad_active), 1);
   endtask

   task automatic test_vs_abort();
      set_vpos(8'd0);
      vs_pulse();
      hs_pulses(20);
      check("abort pre active", int'(if0.pad_active), 1);
      @(negedge clk) begin vsync = 1'b1; hsync = 1'b1; end
      @(negedge clk);
      check("abort drop", int'(if0.pad_active), 0);
      vsync = 1'b0;
      hsync = 1'b0;
      hs_pulses(15);
      check("abort hs15", int'(if0.pad_active), 0);
      hs_pulses(1);
      check("abort hs16", int'(if0.pad_active), 1);
   endtask

   task automatic test_zero_offset_and_short();
      logic seen;
      set_vpos(8'd0);
      @(negedge clk) vsync = 1'b1;
      @(negedge clk);
      check("zoff active on vs", int'(if1.pad_active), 1);
      check("zoff start on vs", int'(if1.pad_start), 1);
      vsync = 1'b0;
      @(negedge clk);
      check("zoff start 1 cycle", int'(if1.pad_start), 0);
      hs_pulses(15);
      check("zoff hs15", int'(if1.pad_active), 1);
      hs_pulses(1);
      check("zoff hs16", int'(if1.pad_active), 0);
      set_vpos(8'd255);
      vs_pulse();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         hs_pulses(1);
         seen = seen | if0.pad_active;
      end
      vs_pulse();
      seen = seen | if0.pad_active;
      check("short frame no window", int'(seen), 0);
   endtask

   task automatic test_reset_mid();
      logic seen;
      set_vpos(8'd1);
      vs_pulse();
      hs_pulses(18);
      check("rst pre active", int'(if0.pad_active), 1);
      check("rst pre frame_vpos", int'(if0.frame_vpos), 1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst async active", int'(if0.pad_active), 0);
      check("rst async frame_vpos", int'(if0.frame_vpos), 0);
      check("rst async start", int'(if0.pad_start), 0);
      @(negedge clk) reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         hs_pulses(1);
         seen = seen | if0.pad_active;
      end
      check("rst hs only no window", int'(seen), 0);
      vs_pulse();
      check("rst hold cleared", int'(if0.frame_vpos), 0);
      hs_pulses(16);
      check("rst next frame hs16", int'(if0.pad_active), 1);
   endtask

   initial begin
      test_reset();
      test_vpos0();
      test_vpos_range();
      test_midframe_load();
      test_vs_abort();
      test_zero_offset_and_short();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
